fp8_mul_seq: RTL

- Sequential multiplier for the team's 8-bit minifloat format; the inverse operation of the Goldschmidt divider datapath.
- Computes p = a × b with a multi-cycle radix-4 Booth shift-add mantissa core, one Booth digit per clock.
- Valid/ready handshakes on input and output.
- Sits beside the divider so quotient results can be checked and rescaled, e.g. Q × B ≈ A.

---
 rtl/fp8_mul_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fp8_mul_seq.sv
// fp8_mul_seq: sequential multiplier for the 8-bit minifloat format
// (1 sign, 4 exponent bits with bias 7, 3 fraction bits with a hidden 1).
// The mantissa product is built by a radix-4 Booth shift-add core that
// retires one Booth digit per clock. The result is then normalised by
// truncation, and saturated or flushed when it falls out of range.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready is high only in IDLE)
//   a, b                operands: [7] sign, [6:3] exponent, [2:0] fraction
//   out_valid/out_ready result handshake; p/ovf/unf stay stable while stalled
//   p                   product, in the same format as the operands
//   ovf                 result saturated to the largest magnitude
//   unf                 result flushed to zero by underflow
//
// Only the default parameter values are supported. The Booth digit schedule
// assumes a 4-bit mantissa.
module fp8_mul_seq #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int BIAS  = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   p,
    output logic                   ovf,
    output logic                   unf
);
    localparam int W = 1 + EXP_W + MAN_W;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t              state_q;
    logic [1:0]          cnt_q;
    logic [W-2:0]        a_q, b_q;      // exponent + fraction only; sign is pre-combined
    logic                sign_q, zero_q;
    logic signed [9:0]   acc_q, acc_d;
    logic                in_ready_q, out_valid_q, ovf_q, unf_q;
    logic [W-1:0]        p_q;

    // ---------------- Booth digit step ----------------
    logic [MAN_W:0]      ma, mb;
    logic [2:0]          trip;
    logic signed [9:0]   ma_s, pp, pp_sh;

    assign ma   = {1'b1, a_q[MAN_W-1:0]};
    assign mb   = {1'b1, b_q[MAN_W-1:0]};
    assign ma_s = $signed({6'b0, ma});

    always_comb begin
        // mb is zero-extended to 6 bits with an implied 0 below bit 0.
        trip = 3'b000;
        case (cnt_q)
            2'd0:    trip = {mb[1], mb[0], 1'b0};
            2'd1:    trip = {mb[3], mb[2], mb[1]};
            default: trip = {2'b00, mb[3]};
        endcase
    end

    always_comb begin
        pp = '0;
        case (trip)
            3'b001, 3'b010: pp = ma_s;
            3'b011:         pp = ma_s <<< 1;
            3'b100:         pp = -(ma_s <<< 1);
            3'b101, 3'b110: pp = -ma_s;
            default:        pp = '0;
        endcase
        // Digit k carries weight 4^k.
        pp_sh = pp <<< {cnt_q, 1'b0};
        acc_d = acc_q + pp_sh;
    end

    // ---------------- normalise / pack ----------------
    logic [7:0]          prod;
    logic [MAN_W-1:0]    frac;
    logic signed [5:0]   exp_s;
    logic [W-1:0]        p_d;
    logic                ovf_d, unf_d;

    assign prod = acc_q[7:0];

    always_comb begin
        // The binary point sits between prod[6] and prod[5]. A product >= 2.0
        // moves it one place up and bumps the exponent.
        frac  = prod[7] ? prod[6:4] : prod[5:3];
        exp_s = $signed({2'b00, a_q[W-2:MAN_W]}) + $signed({2'b00, b_q[W-2:MAN_W]})
              - $signed(6'(BIAS)) + $signed({5'b0, prod[7]});
        p_d   = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (zero_q) begin
            p_d = '0;                       // a zero operand beats both flags
        end else if (exp_s > 6'sd15) begin
            p_d   = {sign_q, {(W-1){1'b1}}};
            ovf_d = 1'b1;
        end else if (exp_s < 6'sd1) begin
            unf_d = 1'b1;
        end else begin
            p_d = {sign_q, exp_s[EXP_W-1:0], frac};
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q        <= a[W-2:0];
                    b_q        <= b[W-2:0];
                    sign_q     <= a[W-1] ^ b[W-1];
                    zero_q     <= (a[W-2:MAN_W] == '0) || (b[W-2:MAN_W] == '0);
                    acc_q      <= '0;
                    cnt_q      <= '0;
                    ovf_q      <= 1'b0;
                    unf_q      <= 1'b0;
                    in_ready_q <= 1'b0;
                    state_q    <= MUL;
                end
                MUL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd2) state_q <= NORM;
                end
                NORM: begin
                    p_q         <= p_d;
                    ovf_q       <= ovf_d;
                    unf_q       <= unf_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (out_ready) begin
                    // Re-enter IDLE only after the consume edge, so a new
                    // operand is never taken in the same cycle.
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule
